// File: rtl/spi_frame_capture.sv
// Read-only SPI mode-0 master: captures one MSB-first FRAME_BITS word from the sensor per frame.
// Optional macro AUTO_TRIGGER_EN adds a free-running SAMPLE_PERIOD frame trigger.
module spi_frame_capture #(
  parameter int CLK_DIV       = 4,
  parameter int FRAME_BITS    = 24,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic [FRAME_BITS-1:0] d_out,
  output logic                  d_valid,
  output logic                  busy
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } state_t;

  if (CLK_DIV < 2) begin : g_bad_div
    $error("CLK_DIV must be 2 or more");
  end
  if (FRAME_BITS < 8 || FRAME_BITS > 32) begin : g_bad_bits
    $error("FRAME_BITS must be within 8..32");
  end

  state_t                state_reg, state_next;
  logic [DIV_W-1:0]      div_reg, div_next;
  logic [BIT_W-1:0]      bit_reg, bit_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [FRAME_BITS-1:0] d_out_reg, d_out_next;
  logic                  sclk_reg, sclk_next;
  logic                  cs_n_reg, cs_n_next;
  logic                  d_valid_reg, d_valid_next;
  logic                  busy_reg, busy_next;
  logic                  div_done, last_bit, trig;

  assign div_done = (div_reg == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_reg == BIT_W'(FRAME_BITS - 1));

`ifdef AUTO_TRIGGER_EN
  localparam int SP_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;

  if (SAMPLE_PERIOD <= CLK_DIV * (2 * FRAME_BITS + 3)) begin : g_bad_period
    $error("SAMPLE_PERIOD must exceed one full frame");
  end

  logic [SP_W-1:0] sample_cnt_reg;
  logic            sample_wrap;

  assign sample_wrap = (sample_cnt_reg == SP_W'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt_reg <= '0;
    end else begin
      sample_cnt_reg <= sample_wrap ? '0 : sample_cnt_reg + 1'b1;
    end
  end

  // A wrap that lands while a frame is in flight is dropped, never queued.
  assign trig = start | (sample_wrap & ~busy_reg);
`else
  if (SAMPLE_PERIOD < 1) begin : g_bad_period
    $error("SAMPLE_PERIOD must be positive");
  end

  assign trig = start;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      div_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      d_out_reg   <= '0;
      sclk_reg    <= 1'b0;
      cs_n_reg    <= 1'b1;
      d_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      d_out_reg   <= d_out_next;
      sclk_reg    <= sclk_next;
      cs_n_reg    <= cs_n_next;
      d_valid_reg <= d_valid_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (trig) state_next = SETUP;
      SETUP:    if (div_done) state_next = SHIFT_LO;
      SHIFT_LO: if (div_done) state_next = SHIFT_HI;
      SHIFT_HI: if (div_done) state_next = last_bit ? HOLD : SHIFT_LO;
      HOLD:     if (div_done) state_next = GAP;
      // The last GAP cycle doubles as the IDLE sample so held start runs back-to-back.
      GAP:      if (div_done) state_next = trig ? SETUP : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    div_next     = (state_reg == IDLE || div_done) ? '0 : div_reg + 1'b1;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    d_out_next   = d_out_reg;
    sclk_next    = sclk_reg;
    cs_n_next    = cs_n_reg;
    d_valid_next = 1'b0;
    busy_next    = busy_reg;
    case (state_reg)
      IDLE: begin
        if (trig) begin
          cs_n_next = 1'b0;
          busy_next = 1'b1;
          bit_next  = '0;
        end
      end
      SHIFT_LO: begin
        if (div_done) begin
          sclk_next  = 1'b1;
          shift_next = {shift_reg[FRAME_BITS-2:0], miso};
        end
      end
      SHIFT_HI: begin
        if (div_done) begin
          sclk_next = 1'b0;
          if (!last_bit) bit_next = bit_reg + 1'b1;
        end
      end
      HOLD: begin
        if (div_done) begin
          cs_n_next    = 1'b1;
          d_out_next   = shift_reg;
          d_valid_next = 1'b1;
        end
      end
      GAP: begin
        if (div_done) begin
          if (trig) begin
            cs_n_next = 1'b0;
            bit_next  = '0;
          end else begin
            busy_next = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign sclk    = sclk_reg;
  assign cs_n    = cs_n_reg;
  assign d_out   = d_out_reg;
  assign d_valid = d_valid_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_spi_frame_capture.sv
// Directed bench for spi_frame_capture with a mode-0 sensor model driving miso.
module tb_spi_frame_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        miso = 1'b0;
  logic        sclk, cs_n, d_valid, busy;
  logic [23:0] d_out;

  always #5 clk = ~clk;

  spi_frame_capture #(
    .CLK_DIV      (4),
    .FRAME_BITS   (24),
    .SAMPLE_PERIOD(500)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .miso   (miso),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .d_out  (d_out),
    .d_valid(d_valid),
    .busy   (busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sensor: MSB presented when cs_n falls, next bit after each sclk fall.
  logic [23:0] sensor_word = '0;
  int          bit_idx = 0;
  always @(negedge cs_n) begin
    bit_idx = 23;
    miso = sensor_word[23];
  end
  always @(negedge sclk) begin
    if (!cs_n) begin
      bit_idx--;
      if (bit_idx >= 0) miso = sensor_word[bit_idx];
    end
  end

  int sclk_edges = 0;
  always @(posedge sclk) sclk_edges++;

  int          dv_count = 0;
  int          dv_consec_err = 0;
  int          dout_change_err = 0;
  logic        dv_prev = 1'b0;
  logic [23:0] dout_prev = '0;
  always @(negedge clk) begin
    if (d_valid) dv_count++;
    if (d_valid && dv_prev) dv_consec_err++;
    if (reset && !d_valid && d_out !== dout_prev) dout_change_err++;
    dv_prev = d_valid;
    dout_prev = d_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic run_frame(input logic [23:0] w, input int poke_at);
    int lat;
    int dv0;
    sensor_word = w;
    sclk_edges = 0;
    dv0 = dv_count;
    lat = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("cs_fall", {31'd0, cs_n}, 32'd0);
    check("busy_rise", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = (k == poke_at);
      if (d_valid) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check("latency", lat, 32'd200);
    check("d_out", {8'd0, d_out}, {8'd0, w});
    check("sclk_edges", sclk_edges, 32'd24);
    repeat (3) @(negedge clk);
    check("d_out_held", {8'd0, d_out}, {8'd0, w});
    check("dv_low", {31'd0, d_valid}, 32'd0);
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("dv_once", dv_count - dv0, 32'd1);
    $display("[TB] frame %h: d_out %h latency %0d sclk edges %0d", w, d_out, lat, sclk_edges);
  endtask

  initial begin
    int bad;
    int stamps[$];
    int run;
    int min_run;
    logic seen_low;

    // Reset hold and idle quiet period
    repeat (3) begin
      @(negedge clk);
      check("rst_sclk", {31'd0, sclk}, 32'd0);
      check("rst_cs_n", {31'd0, cs_n}, 32'd1);
      check("rst_d_out", {8'd0, d_out}, 32'd0);
      check("rst_dv", {31'd0, d_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    reset = 1'b1;

`ifdef AUTO_TRIGGER_EN
    sensor_word = 24'h000064;
    bad = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (!cs_n) begin
        bad = k;
        break;
      end
    end
    check("auto_first", bad, 32'd500);
    for (int k = 0; k < 1300 && stamps.size() < 3; k++) begin
      @(negedge clk);
      if (d_valid) stamps.push_back(k);
    end
    check("auto_count", stamps.size(), 32'd3);
    for (int i = 1; i < stamps.size(); i++) check("auto_period", stamps[i] - stamps[i-1], 32'd500);
    check("auto_d_out", {8'd0, d_out}, 32'h64);
    $display("[TB] auto-trigger frames seen %0d", stamps.size());
`else
    sclk_edges = 0;
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (sclk !== 1'b0 || cs_n !== 1'b1 || d_valid !== 1'b0 || busy !== 1'b0 || d_out !== '0) bad++;
    end
    check("idle_sclk_edges", sclk_edges, 32'd0);
    check("idle_quiet", bad, 32'd0);
    $display("[TB] idle 500 cycles: sclk edges %0d", sclk_edges);

    run_frame(24'h000064, 0);
    run_frame(24'h000044, 50);
    run_frame(24'h000000, 0);

    // Back-to-back frames with start held high
    sensor_word = 24'h5A5A5A;
    stamps.delete();
    run = 0;
    min_run = 1000;
    seen_low = 1'b0;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (d_valid) stamps.push_back(i);
      if (cs_n) begin
        run++;
      end else begin
        if (seen_low && run > 0 && run < min_run) min_run = run;
        run = 0;
        seen_low = 1'b1;
      end
    end
    start = 1'b0;
    check("b2b_count", stamps.size(), 32'd4);
    for (int i = 1; i < stamps.size(); i++) check("b2b_period", stamps[i] - stamps[i-1], 32'd204);
    check("b2b_cs_gap", {31'd0, (min_run >= 4)}, 32'd1);
    for (int k = 0; k < 300 && busy; k++) @(negedge clk);
    check("b2b_busy_fall", {31'd0, busy}, 32'd0);
    check("b2b_d_out", {8'd0, d_out}, 32'h5A5A5A);
    $display("[TB] back-to-back: %0d pulses, min cs_n gap %0d", stamps.size(), min_run);

    // Reset in the middle of a frame
    sensor_word = 24'hABCDEF;
    sclk_edges = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (sclk_edges >= 12) break;
    end
    check("mid_edges", sclk_edges, 32'd12);
    reset = 1'b0;
    #1;
    check("mid_cs_n", {31'd0, cs_n}, 32'd1);
    check("mid_sclk", {31'd0, sclk}, 32'd0);
    check("mid_d_out", {8'd0, d_out}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset at sclk edge %0d: cs_n %b sclk %b d_out %h", sclk_edges, cs_n, sclk, d_out);
    run_frame(24'h123456, 0);
`endif

    check("dv_consecutive", dv_consec_err, 32'd0);
    check("d_out_stable", dout_change_err, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
